// File: rtl/pipe_ctrl_unit.sv
// Control unit for the 5-stage MIPS-Lite pipe: ID decode, control pipe to WB, load-use stall,
// redirect flush and the MULTU busy interlock (built only when `PIPE_CTRL_MULTU_EN is defined).
module pipe_ctrl_unit #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned RAW     = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [5:0]     id_opcode,
  input  logic [5:0]     id_funct,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           id_br_eq,
  output logic           pc_write,
  output logic           ifid_write,
  output logic           ifid_flush,
  output logic [1:0]     pc_sel,
  output logic           id_ext_sel,
  output logic           ex_regdst,
  output logic           ex_alusrc,
  output logic [1:0]     ex_aluop,
  output logic           mul_start,
  output logic           mul_busy,
  output logic           mem_read,
  output logic           mem_write,
  output logic           wb_regwrite,
  output logic           wb_memtoreg,
  output logic           illegal
);

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_ANDI  = 6'd12;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] FN_JR    = 6'd8;
  localparam logic [5:0] FN_MULTU = 6'd25;

  if (MUL_LAT == 0) begin : g_bad_mul_lat
    $error("pipe_ctrl_unit: MUL_LAT must be at least 1");
  end

  logic           w_regdst;
  logic           w_alusrc;
  logic           w_memtoreg;
  logic           w_regwrite;
  logic           w_memread;
  logic           w_memwrite;
  logic           w_extsel;
  logic           w_illegal;
  logic           w_rd_rt;
  logic [1:0]     w_aluop;
  logic [1:0]     w_redir;
  logic           w_load_use;
  logic           w_busy;
  logic           w_stall;
  logic           w_run;

  logic           r_ex_regdst;
  logic           r_ex_alusrc;
  logic [1:0]     r_ex_aluop;
  logic           r_ex_memread;
  logic           r_ex_memwrite;
  logic           r_ex_regwrite;
  logic           r_ex_memtoreg;
  logic [RAW-1:0] r_ex_rt;
  logic           r_mem_read;
  logic           r_mem_write;
  logic           r_mem_regwrite;
  logic           r_mem_memtoreg;
  logic           r_wb_regwrite;
  logic           r_wb_memtoreg;
  logic           r_illegal;

`ifdef PIPE_CTRL_MULTU_EN
  localparam int unsigned CW = $clog2(MUL_LAT + 1);
  logic           w_is_mul;
  logic           r_ex_is_mul;
  logic [CW-1:0]  r_mul_cnt;
`endif

  // Undefined encodings fall through with every control at 0, i.e. a bubble.
  always_comb begin
    w_regdst   = 1'b0;
    w_alusrc   = 1'b0;
    w_memtoreg = 1'b0;
    w_regwrite = 1'b0;
    w_memread  = 1'b0;
    w_memwrite = 1'b0;
    w_aluop    = 2'b00;
    w_extsel   = 1'b0;
    w_illegal  = 1'b0;
    w_rd_rt    = 1'b0;
    w_redir    = 2'b00;
`ifdef PIPE_CTRL_MULTU_EN
    w_is_mul   = 1'b0;
`endif
    case (id_opcode)
      OP_RTYPE: begin
        if (id_funct == FN_JR) begin
          w_redir = 2'b11;
        end else if (id_funct == FN_MULTU) begin
`ifdef PIPE_CTRL_MULTU_EN
          w_is_mul  = 1'b1;
`else
          w_illegal = 1'b1;
`endif
        end else begin
          w_regdst   = 1'b1;
          w_regwrite = 1'b1;
          w_aluop    = 2'b10;
          w_rd_rt    = 1'b1;
        end
      end
      OP_ADDIU: begin
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
        w_extsel   = 1'b1;
      end
      OP_ANDI: begin
        w_alusrc   = 1'b1;
        w_regwrite = 1'b1;
        w_aluop    = 2'b11;
      end
      OP_LW: begin
        w_alusrc   = 1'b1;
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
        w_memread  = 1'b1;
        w_extsel   = 1'b1;
      end
      OP_SW: begin
        w_alusrc   = 1'b1;
        w_memwrite = 1'b1;
        w_extsel   = 1'b1;
        w_rd_rt    = 1'b1;
      end
      OP_BEQ: begin
        w_aluop  = 2'b01;
        w_extsel = 1'b1;
        w_rd_rt  = 1'b1;
        w_redir  = id_br_eq ? 2'b01 : 2'b00;
      end
      OP_BNE: begin
        w_aluop  = 2'b01;
        w_extsel = 1'b1;
        w_rd_rt  = 1'b1;
        w_redir  = id_br_eq ? 2'b00 : 2'b01;
      end
      OP_J: begin
        w_redir = 2'b10;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  assign w_load_use = r_ex_memread && (r_ex_rt != '0) &&
                      ((r_ex_rt == id_rs) || (w_rd_rt && (r_ex_rt == id_rt)));

`ifdef PIPE_CTRL_MULTU_EN
  assign w_busy    = (r_mul_cnt != '0);
  assign mul_start = rst_n & r_ex_is_mul;
`else
  assign w_busy    = 1'b0;
  assign mul_start = 1'b0;
`endif

  // Busy outranks load-use; either one suppresses the redirect until the front end runs again.
  assign w_stall    = w_busy | w_load_use;
  assign w_run      = rst_n & ~w_stall;
  assign pc_write   = w_run;
  assign ifid_write = w_run;
  assign ifid_flush = w_run & (w_redir != 2'b00);
  assign pc_sel     = w_run ? w_redir : 2'b00;
  assign id_ext_sel = rst_n & w_extsel;
  assign mul_busy   = rst_n & w_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_regdst    <= 1'b0;
      r_ex_alusrc    <= 1'b0;
      r_ex_aluop     <= 2'b00;
      r_ex_memread   <= 1'b0;
      r_ex_memwrite  <= 1'b0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memtoreg  <= 1'b0;
      r_ex_rt        <= '0;
      r_mem_read     <= 1'b0;
      r_mem_write    <= 1'b0;
      r_mem_regwrite <= 1'b0;
      r_mem_memtoreg <= 1'b0;
      r_wb_regwrite  <= 1'b0;
      r_wb_memtoreg  <= 1'b0;
      r_illegal      <= 1'b0;
    end else begin
      if (w_stall) begin
        r_ex_regdst   <= 1'b0;
        r_ex_alusrc   <= 1'b0;
        r_ex_aluop    <= 2'b00;
        r_ex_memread  <= 1'b0;
        r_ex_memwrite <= 1'b0;
        r_ex_regwrite <= 1'b0;
        r_ex_memtoreg <= 1'b0;
        r_ex_rt       <= '0;
      end else begin
        r_ex_regdst   <= w_regdst;
        r_ex_alusrc   <= w_alusrc;
        r_ex_aluop    <= w_aluop;
        r_ex_memread  <= w_memread;
        r_ex_memwrite <= w_memwrite;
        r_ex_regwrite <= w_regwrite;
        r_ex_memtoreg <= w_memtoreg;
        r_ex_rt       <= id_rt;
      end
      r_mem_read     <= r_ex_memread;
      r_mem_write    <= r_ex_memwrite;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memtoreg <= r_ex_memtoreg;
      r_wb_regwrite  <= r_mem_regwrite;
      r_wb_memtoreg  <= r_mem_memtoreg;
      // One pulse per undefined instruction, even if it sits in ID across a stall.
      r_illegal      <= w_illegal & ~w_stall;
    end
  end

`ifdef PIPE_CTRL_MULTU_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_is_mul <= 1'b0;
      r_mul_cnt   <= '0;
    end else begin
      r_ex_is_mul <= w_is_mul & ~w_stall;
      if (r_ex_is_mul) begin
        r_mul_cnt <= CW'(MUL_LAT - 1);
      end else if (r_mul_cnt != '0) begin
        r_mul_cnt <= r_mul_cnt - 1'b1;
      end
    end
  end
`endif

  assign ex_regdst   = r_ex_regdst;
  assign ex_alusrc   = r_ex_alusrc;
  assign ex_aluop    = r_ex_aluop;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign wb_regwrite = r_wb_regwrite;
  assign wb_memtoreg = r_wb_memtoreg;
  assign illegal     = r_illegal;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: reset, load-use, redirects, decode fields, illegal and MULTU.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] OP_R  = 6'd0;
  localparam logic [5:0] OP_J  = 6'd2;
  localparam logic [5:0] OP_BQ = 6'd4;
  localparam logic [5:0] OP_BN = 6'd5;
  localparam logic [5:0] OP_AI = 6'd9;
  localparam logic [5:0] OP_AN = 6'd12;
  localparam logic [5:0] OP_LW = 6'd35;
  localparam logic [5:0] OP_SW = 6'd43;
  localparam logic [5:0] OP_XX = 6'd63;

  logic       clk;
  logic       rst_n;
  logic [5:0] id_opcode;
  logic [5:0] id_funct;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_br_eq;
  logic       pc_write, ifid_write, ifid_flush, id_ext_sel;
  logic [1:0] pc_sel, ex_aluop;
  logic       ex_regdst, ex_alusrc, mul_start, mul_busy;
  logic       mem_read, mem_write, wb_regwrite, wb_memtoreg, illegal;

  int n_total = 0;
  int n_bad   = 0;

  wire [16:0] all_o = {pc_write, ifid_write, ifid_flush, pc_sel, id_ext_sel, ex_regdst,
                       ex_alusrc, ex_aluop, mul_start, mul_busy, mem_read, mem_write,
                       wb_regwrite, wb_memtoreg, illegal};
  wire [3:0]  ex_b  = {ex_regdst, ex_alusrc, ex_aluop};

  pipe_ctrl_unit #(.MUL_LAT(4), .RAW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_br_eq(id_br_eq),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .pc_sel(pc_sel), .id_ext_sel(id_ext_sel), .ex_regdst(ex_regdst),
    .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop), .mul_start(mul_start),
    .mul_busy(mul_busy), .mem_read(mem_read), .mem_write(mem_write),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction in ID and let the combinational outputs settle mid-cycle.
  task automatic put(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                     input logic [4:0] rt, input logic eq);
    id_opcode = op;
    id_funct  = fn;
    id_rs     = rs;
    id_rt     = rt;
    id_br_eq  = eq;
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    put(OP_LW, 6'd0, 5'd1, 5'd9, 1'b0);
    tick(); tick(); tick();
    #3;
    check("reset_all_zero", 32'(all_o), 32'd0);

    // A: LW $t1 decoded on the first cycle out of reset
    rst_n = 1'b1;
    put(OP_LW, 6'd0, 5'd1, 5'd9, 1'b0);
    check("A_pc_write", 32'(pc_write), 32'd1);
    check("A_ifid_write", 32'(ifid_write), 32'd1);
    check("A_ext_sel_lw", 32'(id_ext_sel), 32'd1);
    check("A_wb_regwrite", 32'(wb_regwrite), 32'd0);
    tick();
    // B: ADD $t2,$t1,$t3 hits the load-use hazard
    put(OP_R, 6'd32, 5'd9, 5'd11, 1'b0);
    check("B_stall_pc", 32'(pc_write), 32'd0);
    check("B_stall_ifid", 32'(ifid_write), 32'd0);
    check("B_ex_lw", 32'(ex_b), 32'b0100);
    check("B_wb_regwrite", 32'(wb_regwrite), 32'd0);
    tick();
    // C: stall lasts one cycle, bubble in EX, LW in MEM
    put(OP_R, 6'd32, 5'd9, 5'd11, 1'b0);
    check("C_pc_write", 32'(pc_write), 32'd1);
    check("C_ex_bubble", 32'(ex_b), 32'd0);
    check("C_mem_read", 32'(mem_read), 32'd1);
    check("C_wb_regwrite", 32'(wb_regwrite), 32'd0);
    tick();
    // D: ADD reaches EX, LW reaches WB; LW to $0 enters ID
    put(OP_LW, 6'd0, 5'd2, 5'd0, 1'b0);
    check("D_ex_add", 32'(ex_b), 32'b1010);
    check("D_mem_read", 32'(mem_read), 32'd0);
    check("D_wb_lw", 32'({wb_regwrite, wb_memtoreg}), 32'b11);
    tick();
    // E: consumer of $0 after LW $0 must not stall
    put(OP_R, 6'd32, 5'd0, 5'd0, 1'b0);
    check("E_no_stall_r0", 32'(pc_write), 32'd1);
    check("E_ex_lw", 32'(ex_alusrc), 32'd1);
    check("E_wb_bubble", 32'({wb_regwrite, wb_memtoreg}), 32'b00);
    tick();
    // F: BNE not equal -> branch taken
    put(OP_BN, 6'd0, 5'd3, 5'd4, 1'b0);
    check("F_bne_taken", 32'({pc_sel, ifid_flush}), 32'b011);
    check("F_wb_add", 32'({wb_regwrite, wb_memtoreg}), 32'b10);
    tick();
    // G: BNE equal -> fall through
    put(OP_BN, 6'd0, 5'd3, 5'd4, 1'b1);
    check("G_bne_not_taken", 32'({pc_sel, ifid_flush}), 32'b000);
    check("G_ex_bne", 32'(ex_b), 32'b0001);
    tick();
    put(OP_AN, 6'd0, 5'd1, 5'd2, 1'b0);
    check("H_ext_andi", 32'(id_ext_sel), 32'd0);
    tick();
    put(OP_SW, 6'd0, 5'd1, 5'd2, 1'b0);
    check("I_ext_sw", 32'(id_ext_sel), 32'd1);
    check("I_ex_andi", 32'(ex_b), 32'b0111);
    tick();
    put(OP_J, 6'd0, 5'd0, 5'd0, 1'b0);
    check("J_jump", 32'({pc_sel, ifid_flush}), 32'b101);
    check("J_ex_sw", 32'(ex_b), 32'b0100);
    check("J_mem_write", 32'(mem_write), 32'd0);
    tick();
    put(OP_R, 6'd8, 5'd31, 5'd0, 1'b0);
    check("K_jr", 32'({pc_sel, ifid_flush}), 32'b111);
    check("K_mem_write", 32'(mem_write), 32'd1);
    tick();
    put(OP_XX, 6'd0, 5'd0, 5'd0, 1'b0);
    check("L_no_redirect", 32'({pc_sel, ifid_flush}), 32'b000);
    check("L_illegal", 32'(illegal), 32'd0);
    tick();
    // M: opcode 63 leaves a bubble; funct 25 enters ID
    put(OP_R, 6'd25, 5'd1, 5'd2, 1'b0);
    check("M_illegal", 32'(illegal), 32'd1);
    check("M_ex_bubble", 32'(ex_b), 32'd0);
    tick();
    put(OP_AI, 6'd0, 5'd1, 5'd2, 1'b0);
    check("N_mem_bubble", 32'({mem_read, mem_write}), 32'd0);
`ifdef PIPE_CTRL_MULTU_EN
    check("N_illegal", 32'(illegal), 32'd0);
    check("N_mul_start", 32'(mul_start), 32'd1);
    check("N_mul_busy", 32'(mul_busy), 32'd0);
    check("N_pc_write", 32'(pc_write), 32'd1);
    tick();
    put(OP_J, 6'd0, 5'd0, 5'd0, 1'b0);
    check("O_mul_busy", 32'(mul_busy), 32'd1);
    check("O_mul_start", 32'(mul_start), 32'd0);
    check("O_frozen", 32'({pc_write, ifid_write, pc_sel, ifid_flush}), 32'd0);
    check("O_ex_addiu", 32'(ex_alusrc), 32'd1);
    check("O_wb_bubble", 32'({wb_regwrite, wb_memtoreg}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      put(OP_J, 6'd0, 5'd0, 5'd0, 1'b0);
      check("PQ_mul_busy", 32'(mul_busy), 32'd1);
      check("PQ_no_redirect", 32'({pc_sel, ifid_flush}), 32'd0);
      check("PQ_ex_bubble", 32'(ex_b), 32'd0);
    end
    tick();
    put(OP_J, 6'd0, 5'd0, 5'd0, 1'b0);
    check("R_busy_fell", 32'(mul_busy), 32'd0);
    check("R_jump_taken", 32'({pc_write, pc_sel, ifid_flush}), 32'b1101);
`else
    check("N_illegal", 32'(illegal), 32'd1);
    check("N_mul_start", 32'(mul_start), 32'd0);
    check("N_mul_busy", 32'(mul_busy), 32'd0);
    tick();
    put(OP_J, 6'd0, 5'd0, 5'd0, 1'b0);
    check("O_jump", 32'({pc_write, pc_sel, ifid_flush}), 32'b1101);
    check("O_illegal", 32'(illegal), 32'd0);
    check("O_wb_bubble", 32'({wb_regwrite, wb_memtoreg}), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      put(OP_R, 6'd25, 5'd1, 5'd2, 1'b0);
      check("nomul_busy", 32'({mul_busy, mul_start}), 32'd0);
      check("nomul_pc_write", 32'(pc_write), 32'd1);
    end
`endif
    tick();
    put(OP_LW, 6'd0, 5'd0, 5'd7, 1'b0);
    tick();
    // ADDIU does not read rt, so a match on rt alone is harmless
    put(OP_AI, 6'd0, 5'd1, 5'd7, 1'b0);
    check("T_addiu_no_stall", 32'(pc_write), 32'd1);
    tick();
    put(OP_LW, 6'd0, 5'd0, 5'd7, 1'b0);
    tick();
    put(OP_BQ, 6'd0, 5'd1, 5'd7, 1'b1);
    check("V_beq_stall", 32'({pc_write, pc_sel, ifid_flush}), 32'd0);
    tick();
    put(OP_BQ, 6'd0, 5'd1, 5'd7, 1'b1);
    check("W_beq_after_stall", 32'({pc_write, pc_sel, ifid_flush}), 32'b1011);
    tick();
    put(OP_LW, 6'd0, 5'd0, 5'd7, 1'b0);
    tick();
    put(OP_R, 6'd32, 5'd1, 5'd7, 1'b0);
    check("Y_rtype_rt_stall", 32'(pc_write), 32'd0);
`ifdef PIPE_CTRL_MULTU_EN
    tick();
    put(OP_R, 6'd25, 5'd1, 5'd2, 1'b0);
    tick();
    put(OP_AI, 6'd0, 5'd1, 5'd2, 1'b0);
    check("Z_mul_start", 32'(mul_start), 32'd1);
    tick();
    put(OP_AI, 6'd0, 5'd1, 5'd2, 1'b0);
    check("Z_mul_busy", 32'(mul_busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #3;
    check("Z_reset_aborts_mul", 32'({mul_busy, pc_write}), 32'b01);
`endif
    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
